// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl_if
// Brief    : IF1 fetch-PC bundle: redirect/prediction in, ICache request and
//            IF1->IF2 PC pair out. master = fetch_pc_ctrl, slave = neighbours.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_ctrl_if;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_pred_taken;
    logic [31:0] i_pred_pc;
    logic        i_stall_ICache;
    logic        i_icache_addr_ok;
    logic        o_icache_req;
    logic [31:0] o_icache_addr;
    logic [31:0] o_PC1;
    logic [31:0] o_PC2;
    logic [1:0]  o_is_valid;
    logic        o_pc_busy;
`ifdef FETCH_PC_ALIGN_CHK_EN
    logic        o_adef;
`endif

    modport master (
        input  i_redirect, i_redirect_pc, i_pred_taken, i_pred_pc,
               i_stall_ICache, i_icache_addr_ok,
        output o_icache_req, o_icache_addr, o_PC1, o_PC2, o_is_valid, o_pc_busy
`ifdef FETCH_PC_ALIGN_CHK_EN
        , output o_adef
`endif
    );

    modport slave (
        output i_redirect, i_redirect_pc, i_pred_taken, i_pred_pc,
               i_stall_ICache, i_icache_addr_ok,
        input  o_icache_req, o_icache_addr, o_PC1, o_PC2, o_is_valid, o_pc_busy
`ifdef FETCH_PC_ALIGN_CHK_EN
        , input o_adef
`endif
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_ctrl
// Brief    : IF1 fetch-PC sequencer for the dual-issue front end. Optional
//            misaligned-PC check enabled by macro FETCH_PC_ALIGN_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h1C00_0000,
    parameter int          FETCH_BYTES = 8
) (
    input  logic            clk,
    input  logic            rstn,
    fetch_pc_ctrl_if.master bus
);

    localparam logic [31:0] INSN_BYTES  = 32'd4;
    localparam logic [31:0] GROUP_BYTES = 32'(FETCH_BYTES);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_PEND  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic [31:0] pc1;
    logic [31:0] pc2;
    logic [1:0]  is_valid;
    logic        misaligned;
    logic        req;
    logic        accept;

`ifdef FETCH_PC_ALIGN_CHK_EN
    logic adef;
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign req    = (state == S_FETCH) && !bus.i_stall_ICache && !misaligned;
    assign accept = req && bus.i_icache_addr_ok;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_RESET;
            pc       <= RESET_PC;
            pend_pc  <= 32'd0;
            pc1      <= RESET_PC;
            pc2      <= RESET_PC + INSN_BYTES;
            is_valid <= 2'b00;
`ifdef FETCH_PC_ALIGN_CHK_EN
            adef     <= 1'b0;
`endif
        end else begin
            case (state)
                S_RESET: state <= S_FETCH;
                S_FETCH, S_PEND: begin
                    if (bus.i_stall_ICache) begin
                        // Stage frozen; a redirect is parked until the stall lifts.
                        if (bus.i_redirect) begin
                            pend_pc <= bus.i_redirect_pc;
                            state   <= S_PEND;
`ifdef FETCH_PC_ALIGN_CHK_EN
                            adef    <= 1'b0;
`endif
                        end
                    end else if (bus.i_redirect) begin
                        pc       <= bus.i_redirect_pc;
                        is_valid <= 2'b00;
                        state    <= S_FETCH;
`ifdef FETCH_PC_ALIGN_CHK_EN
                        adef     <= 1'b0;
`endif
                    end else if (state == S_PEND) begin
                        pc       <= pend_pc;
                        is_valid <= 2'b00;
                        state    <= S_FETCH;
                    end else if (bus.i_pred_taken) begin
                        pc       <= bus.i_pred_pc;
                        is_valid <= 2'b00;
`ifdef FETCH_PC_ALIGN_CHK_EN
                    end else if (misaligned) begin
                        // Report the fault once as a slot-0 group, then idle until redirected.
                        if (!adef) begin
                            pc1      <= pc;
                            is_valid <= 2'b01;
                            adef     <= 1'b1;
                        end else begin
                            is_valid <= 2'b00;
                        end
`endif
                    end else if (accept) begin
                        pc1      <= pc;
                        pc2      <= pc + INSN_BYTES;
                        is_valid <= {~pc[2], 1'b1};
                        // Entering at the upper slot yields one instruction, then realigns.
                        pc       <= pc[2] ? (pc + INSN_BYTES) : (pc + GROUP_BYTES);
                    end else begin
                        is_valid <= 2'b00;
                    end
                end
                default: state <= S_RESET;
            endcase
        end
    end

    assign bus.o_icache_req  = req;
    assign bus.o_icache_addr = pc;
    assign bus.o_PC1         = pc1;
    assign bus.o_PC2         = pc2;
    assign bus.o_is_valid    = is_valid;
    assign bus.o_pc_busy     = (state == S_RESET) || (state == S_PEND);
`ifdef FETCH_PC_ALIGN_CHK_EN
    assign bus.o_adef        = adef;
`endif

endmodule
`default_nettype wire
